// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the execute stage:
//   - ALU opcode constants (4-bit EX_AluOp encoding)
//   - Forward-select codes used by ForwardA / ForwardB
//   - The EX/MEM pipeline register layout
// -----------------------------------------------------------------------------
package mips_pkg;

    // ALU opcodes. Code 4'hF is left undefined and yields a zero result.
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOR  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6;
    localparam logic [3:0] ALU_SLTU = 4'h7;
    localparam logic [3:0] ALU_SLL  = 4'h8;
    localparam logic [3:0] ALU_SRL  = 4'h9;
    localparam logic [3:0] ALU_SRA  = 4'hA;
    localparam logic [3:0] ALU_SLLV = 4'hB;
    localparam logic [3:0] ALU_SRLV = 4'hC;
    localparam logic [3:0] ALU_SRAV = 4'hD;
    localparam logic [3:0] ALU_LUI  = 4'hE;

    // Forward-select codes. 2'b11 is treated like FWD_ID.
    localparam logic [1:0] FWD_ID  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // EX/MEM pipeline register contents.
    typedef struct packed {
        logic [31:0] aluResult;
        logic [31:0] writeData;
        logic [4:0]  regRd;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        memToReg;
        logic        zero;
        logic        ovf;
    } exMemReg_t;

    // Three-way forwarding mux shared by both operand paths.
    function automatic logic [31:0] fwdSelect(input logic [1:0]  sel,
                                              input logic [31:0] idVal,
                                              input logic [31:0] memVal,
                                              input logic [31:0] wbVal);
        case (sel)
            FWD_MEM: fwdSelect = memVal;
            FWD_WB:  fwdSelect = wbVal;
            default: fwdSelect = idVal;
        endcase
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// -----------------------------------------------------------------------------
// ex_stage_if
// Bundles the ID/EX-side inputs and the EX/MEM-side outputs of the execute
// stage.
//   slave  : used by ex_stage (consumes EX_* / Forward* / WB_Data,
//            produces MEM_*)
//   master : used by whatever drives the stage (issue logic or a testbench)
// This stage has no handshake: a new operation is presented every cycle and
// the pipeline control is done through i_stall / i_flush on ex_stage itself.
// -----------------------------------------------------------------------------
interface ex_stage_if;

    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic [31:0] EX_RsData;
    logic [31:0] EX_RtData;
    logic [31:0] EX_Imm;
    logic [31:0] WB_Data;
    logic [4:0]  EX_Shamt;
    logic [4:0]  EX_RegRd;
    logic [3:0]  EX_AluOp;
    logic        EX_AluSrc;
    logic        EX_RegWrite;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic        EX_MemToReg;

    logic [31:0] MEM_AluResult;
    logic [31:0] MEM_WriteData;
    logic [4:0]  MEMRegRd;
    logic        MEM_RegWrite;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic        MEM_MemToReg;
    logic        MEM_Zero;
    logic        MEM_Ovf;

    modport slave (
        input  ForwardA, ForwardB, EX_RsData, EX_RtData, EX_Imm, WB_Data,
               EX_Shamt, EX_RegRd, EX_AluOp, EX_AluSrc,
               EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg,
        output MEM_AluResult, MEM_WriteData, MEMRegRd,
               MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_MemToReg,
               MEM_Zero, MEM_Ovf
    );

    modport master (
        output ForwardA, ForwardB, EX_RsData, EX_RtData, EX_Imm, WB_Data,
               EX_Shamt, EX_RegRd, EX_AluOp, EX_AluSrc,
               EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg,
        input  MEM_AluResult, MEM_WriteData, MEMRegRd,
               MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_MemToReg,
               MEM_Zero, MEM_Ovf
    );

endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational 32-bit ALU.
//   opA, opB : operands
//   shamt    : immediate shift amount (SLL/SRL/SRA)
//   aluOp    : operation, see mips_pkg ALU_* constants
//   result   : 32-bit result (0 for undefined opcodes)
//   zero     : result == 0
//   ovf      : signed overflow, only for ADD and SUB
// -----------------------------------------------------------------------------
module alu
    import mips_pkg::*;
(
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  shamt,
    input  logic [3:0]  aluOp,
    output logic [31:0] result,
    output logic        zero,
    output logic        ovf
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = opA + opB;
    assign diff = opA - opB;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (aluOp)
            ALU_ADD: begin
                result = sum;
                // Same-sign operands producing a different-sign sum.
                ovf    = (opA[31] == opB[31]) && (sum[31] != opA[31]);
            end
            ALU_SUB: begin
                result = diff;
                // Different-sign operands where the sign of A is not kept.
                ovf    = (opA[31] != opB[31]) && (diff[31] != opA[31]);
            end
            ALU_AND:  result = opA & opB;
            ALU_OR:   result = opA | opB;
            ALU_XOR:  result = opA ^ opB;
            ALU_NOR:  result = ~(opA | opB);
            ALU_SLT:  result = {31'b0, ($signed(opA) < $signed(opB))};
            ALU_SLTU: result = {31'b0, (opA < opB)};
            ALU_SLL:  result = opB << shamt;
            ALU_SRL:  result = opB >> shamt;
            ALU_SRA:  result = $signed(opB) >>> shamt;
            ALU_SLLV: result = opB << opA[4:0];
            ALU_SRLV: result = opB >> opA[4:0];
            ALU_SRAV: result = $signed(opB) >>> opA[4:0];
            ALU_LUI:  result = {opB[15:0], 16'b0};
            default: begin
                result = '0;
                ovf    = 1'b0;
            end
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Execute stage of a 5-stage MIPS-style pipeline: operand forwarding muxes,
// one ALU and the EX/MEM pipeline register.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset, clears the EX/MEM register
//   i_stall : hold the EX/MEM register
//   i_flush : load a bubble (all zeros) into the EX/MEM register
//   exIf    : ex_stage_if.slave carrying the EX_* inputs, forward selects,
//             WB_Data and the registered MEM_* outputs
// Update priority on each edge: reset, flush, stall, normal load.
// -----------------------------------------------------------------------------
module ex_stage
    import mips_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           i_stall,
    input  logic           i_flush,
    ex_stage_if.slave      exIf
);

    exMemReg_t   exMem;
    exMemReg_t   exMemNext;

    logic [31:0] opA;
    logic [31:0] rtFwd;
    logic [31:0] opB;
    logic [31:0] aluResult;
    logic        aluZero;
    logic        aluOvf;

    // The MEM forward path reads the register, not the ALU output, so a
    // stall with ForwardA = MEM just keeps recomputing from the held value.
    assign opA   = fwdSelect(exIf.ForwardA, exIf.EX_RsData, exMem.aluResult, exIf.WB_Data);
    assign rtFwd = fwdSelect(exIf.ForwardB, exIf.EX_RtData, exMem.aluResult, exIf.WB_Data);
    assign opB   = exIf.EX_AluSrc ? exIf.EX_Imm : rtFwd;

    alu u_alu (
        .opA    (opA),
        .opB    (opB),
        .shamt  (exIf.EX_Shamt),
        .aluOp  (exIf.EX_AluOp),
        .result (aluResult),
        .zero   (aluZero),
        .ovf    (aluOvf)
    );

    always_comb begin
        exMemNext           = '0;
        exMemNext.aluResult = aluResult;
        // Store data is always the forwarded rt, even for immediate ops.
        exMemNext.writeData = rtFwd;
        exMemNext.regRd     = exIf.EX_RegRd;
        // An overflowing ADD/SUB must not update the register file.
        exMemNext.regWrite  = exIf.EX_RegWrite & ~aluOvf;
        exMemNext.memRead   = exIf.EX_MemRead;
        exMemNext.memWrite  = exIf.EX_MemWrite;
        exMemNext.memToReg  = exIf.EX_MemToReg;
        exMemNext.zero      = aluZero;
        exMemNext.ovf       = aluOvf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exMem <= '0;
        end else if (i_flush) begin
            exMem <= '0;
        end else if (!i_stall) begin
            exMem <= exMemNext;
        end
    end

    assign exIf.MEM_AluResult = exMem.aluResult;
    assign exIf.MEM_WriteData = exMem.writeData;
    assign exIf.MEMRegRd      = exMem.regRd;
    assign exIf.MEM_RegWrite  = exMem.regWrite;
    assign exIf.MEM_MemRead   = exMem.memRead;
    assign exIf.MEM_MemWrite  = exMem.memWrite;
    assign exIf.MEM_MemToReg  = exMem.memToReg;
    assign exIf.MEM_Zero      = exMem.zero;
    assign exIf.MEM_Ovf       = exMem.ovf;

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage
// Scoreboard bench for ex_stage. The driver sets inputs on the falling edge
// and pushes the expected post-edge outputs, computed by a behavioural model,
// into exp_q. The monitor samples 1 time unit after each rising edge and
// compares against the head of the queue.
// -----------------------------------------------------------------------------
module tb_ex_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic i_stall;
    logic i_flush;

    ex_stage_if exIf ();

    ex_stage dut (
        .clk     (clk),
        .reset   (reset),
        .i_stall (i_stall),
        .i_flush (i_flush),
        .exIf    (exIf)
    );

    always #5 clk = ~clk;

    // Expected entry: {zeroCare, aluResult, writeData, regRd, regWrite,
    //                  memRead, memWrite, memToReg, zero, ovf}
    logic [75:0] exp_q[$];
    string       tag_q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          started  = 1'b0;
    bit          done     = 1'b0;

    // Model of the architecturally visible EX/MEM state.
    logic [31:0] mRes = '0;
    logic [31:0] mWd  = '0;
    logic [4:0]  mRd  = '0;
    logic        mRw = 1'b0, mMr = 1'b0, mMw = 1'b0, mMtr = 1'b0;
    logic        mZero = 1'b0, mOvf = 1'b0, mCare = 1'b1;

    // Reference ALU written with plain integer arithmetic.
    function automatic void refAlu(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh,
                                   output logic [31:0] r, output logic v);
        longint sa;
        longint sb;
        longint s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        v  = 1'b0;
        case (op)
            ALU_ADD:  begin s = sa + sb; r = 32'(s); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            ALU_SUB:  begin s = sa - sb; r = 32'(s); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            ALU_SLL:  r = 32'(longint'(b) * (64'd1 << sh));
            ALU_SRL:  r = 32'(longint'(b) / (64'd1 << sh));
            ALU_SRA:  r = 32'(sb >>> sh);
            ALU_SLLV: r = 32'(longint'(b) * (64'd1 << (a % 32)));
            ALU_SRLV: r = 32'(longint'(b) / (64'd1 << (a % 32)));
            ALU_SRAV: r = 32'(sb >>> (a % 32));
            ALU_LUI:  r = 32'(longint'(b) * 65536);
            default:  r = '0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] fwd, input logic [31:0] idVal);
        if (fwd == 2'b10)      pick = mRes;
        else if (fwd == 2'b01) pick = exIf.WB_Data;
        else                   pick = idVal;
    endfunction

    // Evaluate the current inputs against the model and queue the result.
    task automatic issue(input string tag);
        logic [31:0] a, rtv, b, r;
        logic        v;
        a   = pick(exIf.ForwardA, exIf.EX_RsData);
        rtv = pick(exIf.ForwardB, exIf.EX_RtData);
        b   = exIf.EX_AluSrc ? exIf.EX_Imm : rtv;
        refAlu(exIf.EX_AluOp, a, b, exIf.EX_Shamt, r, v);
        if (reset || i_flush) begin
            mRes = '0; mWd = '0; mRd = '0;
            mRw = 0; mMr = 0; mMw = 0; mMtr = 0; mZero = 0; mOvf = 0;
            mCare = reset; // zero flag is a don't-care after a flush
        end else if (!i_stall) begin
            mRes = r; mWd = rtv; mRd = exIf.EX_RegRd;
            mRw  = exIf.EX_RegWrite && !v;
            mMr  = exIf.EX_MemRead; mMw = exIf.EX_MemWrite; mMtr = exIf.EX_MemToReg;
            mZero = (r == 0); mOvf = v; mCare = 1'b1;
        end
        exp_q.push_back({mCare, mRes, mWd, mRd, mRw, mMr, mMw, mMtr, mZero, mOvf});
        tag_q.push_back(tag);
        started = 1'b1;
    endtask

    task automatic clearInputs();
        reset = 0; i_stall = 0; i_flush = 0;
        exIf.ForwardA = FWD_ID; exIf.ForwardB = FWD_ID;
        exIf.EX_RsData = '0; exIf.EX_RtData = '0; exIf.EX_Imm = '0; exIf.WB_Data = '0;
        exIf.EX_Shamt = '0; exIf.EX_RegRd = '0; exIf.EX_AluOp = ALU_ADD; exIf.EX_AluSrc = 0;
        exIf.EX_RegWrite = 0; exIf.EX_MemRead = 0; exIf.EX_MemWrite = 0; exIf.EX_MemToReg = 0;
    endtask

    task automatic randInputs();
        exIf.ForwardA    = 2'($urandom_range(0, 3));
        exIf.ForwardB    = 2'($urandom_range(0, 3));
        exIf.EX_RsData   = $urandom();
        exIf.EX_RtData   = $urandom();
        exIf.EX_Imm      = $urandom();
        exIf.WB_Data     = $urandom();
        exIf.EX_Shamt    = 5'($urandom_range(0, 31));
        exIf.EX_RegRd    = 5'($urandom_range(0, 31));
        exIf.EX_AluOp    = 4'($urandom_range(0, 15));
        exIf.EX_AluSrc   = 1'($urandom_range(0, 1));
        exIf.EX_RegWrite = 1'($urandom_range(0, 1));
        exIf.EX_MemRead  = 1'($urandom_range(0, 1));
        exIf.EX_MemWrite = 1'($urandom_range(0, 1));
        exIf.EX_MemToReg = 1'($urandom_range(0, 1));
    endtask

    // One directed register-register or register-immediate operation.
    task automatic doOp(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] imm, input logic aluSrc,
                        input logic [1:0] fa, input logic [31:0] wb, input logic [4:0] sh);
        @(negedge clk);
        clearInputs();
        exIf.EX_AluOp = op; exIf.EX_RsData = rs; exIf.EX_RtData = rt; exIf.EX_Imm = imm;
        exIf.EX_AluSrc = aluSrc; exIf.ForwardA = fa; exIf.WB_Data = wb; exIf.EX_Shamt = sh;
        exIf.EX_RegWrite = 1'b1; exIf.EX_RegRd = 5'd3;
        issue(tag);
    endtask

    // Monitor: compare every cycle once the driver has started.
    initial begin
        logic [75:0] exp;
        logic [74:0] act;
        logic [74:0] expv;
        string       tag;
        while (!done) begin
            @(posedge clk);
            #1;
            if (done) break;
            if (exp_q.size() != 0) begin
                exp  = exp_q.pop_front();
                tag  = tag_q.pop_front();
                expv = exp[74:0];
                act  = {exIf.MEM_AluResult, exIf.MEM_WriteData, exIf.MEMRegRd,
                        exIf.MEM_RegWrite, exIf.MEM_MemRead, exIf.MEM_MemWrite,
                        exIf.MEM_MemToReg, exIf.MEM_Zero, exIf.MEM_Ovf};
                if (!exp[75]) begin
                    act[1]  = 1'b0;
                    expv[1] = 1'b0;
                end
                checks++;
                if (act !== expv) begin
                    failures++;
                    $display("FAIL %s: got res=%h wd=%h rd=%0d rw/mr/mw/mtr/z/ov=%b expected res=%h wd=%h rd=%0d rw/mr/mw/mtr/z/ov=%b",
                             tag, act[74:43], act[42:11], act[10:6], act[5:0],
                             expv[74:43], expv[42:11], expv[10:6], expv[5:0]);
                end
            end else if (started) begin
                checks++;
                failures++;
                $display("FAIL monitor: output cycle with empty expected queue");
            end
        end
    end

    // Driver.
    initial begin
        clearInputs();
        reset = 1'b1;

        // Reset state.
        repeat (2) begin
            @(negedge clk);
            clearInputs(); reset = 1'b1;
            issue("reset");
        end

        // Signed overflow on ADD suppresses RegWrite but records Ovf.
        doOp("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, FWD_ID, 32'd0, 5'd0);

        // Forwarding from MEM and WB.
        doOp("fwd_seed", ALU_ADD, 32'd2, 32'd0, 32'd3, 1'b1, FWD_ID, 32'd0, 5'd0);
        doOp("fwd_mem", ALU_ADD, 32'd9, 32'd0, 32'd3, 1'b1, FWD_MEM, 32'd0, 5'd0);
        doOp("fwd_wb", ALU_ADD, 32'd9, 32'd0, 32'd3, 1'b1, FWD_WB, 32'd100, 5'd0);

        // Compare and zero flag.
        doOp("sub_zero", ALU_SUB, 32'h1234, 32'h1234, 32'd0, 1'b0, FWD_ID, 32'd0, 5'd0);
        doOp("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, FWD_ID, 32'd0, 5'd0);
        doOp("sltu_neg", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, FWD_ID, 32'd0, 5'd0);

        // Shifts.
        doOp("sra", ALU_SRA, 32'd0, 32'h8000_0000, 32'd0, 1'b0, FWD_ID, 32'd0, 5'd4);
        doOp("srlv", ALU_SRLV, 32'd36, 32'h8000_0000, 32'd0, 1'b0, FWD_ID, 32'd0, 5'd0);
        doOp("lui", ALU_LUI, 32'd0, 32'd0, 32'h0000_ABCD, 1'b1, FWD_ID, 32'd0, 5'd0);
        doOp("undef_op", 4'hF, 32'h1234, 32'h5678, 32'd0, 1'b0, FWD_ID, 32'd0, 5'd0);

        // Stall for 3 cycles while inputs change, then flush during stall.
        @(negedge clk);
        clearInputs(); randInputs(); exIf.EX_MemWrite = 1'b1; exIf.ForwardA = FWD_ID;
        issue("stall_load");
        repeat (3) begin
            @(negedge clk);
            clearInputs(); randInputs(); i_stall = 1'b1;
            issue("stall_hold");
        end
        @(negedge clk);
        clearInputs(); randInputs(); i_stall = 1'b1; i_flush = 1'b1;
        issue("flush_stall");

        // Reset during a stall holding MemWrite = 1, then a normal load.
        @(negedge clk);
        clearInputs(); randInputs(); exIf.EX_MemWrite = 1'b1;
        issue("pre_rst_load");
        @(negedge clk);
        clearInputs(); randInputs(); i_stall = 1'b1;
        issue("pre_rst_stall");
        @(negedge clk);
        clearInputs(); randInputs(); i_stall = 1'b1; reset = 1'b1;
        issue("rst_in_stall");
        @(negedge clk);
        clearInputs(); randInputs();
        issue("post_rst_load");

        // Randomized traffic with occasional stall / flush / reset.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            clearInputs(); randInputs();
            i_stall = ($urandom_range(0, 99) < 20);
            i_flush = ($urandom_range(0, 99) < 8);
            reset   = ($urandom_range(0, 99) < 2);
            issue("random");
        end

        @(posedge clk);
        #2;
        done = 1'b1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port i_stall, input, 1 bit: hold the EX/MEM register.
REQ-004 SHALL have port i_flush, input, 1 bit: load a bubble into the EX/MEM register.
REQ-005 SHALL have ports ForwardA and ForwardB, input, 2 bits each: operand select, 00 = ID/EX, 10 = MEM, 01 = WB, 11 = ID/EX.
REQ-006 SHALL have ports EX_RsData, EX_RtData, EX_Imm and WB_Data, input, 32 bits each.
REQ-007 SHALL have ports EX_Shamt (input, 5 bits) and EX_RegRd (input, 5 bits): destination register already chosen upstream.
REQ-008 SHALL have port EX_AluOp, input, 4 bits, and port EX_AluSrc, input, 1 bit (1 = operand B is EX_Imm).
REQ-009 SHALL have control inputs EX_RegWrite, EX_MemRead, EX_MemWrite and EX_MemToReg, 1 bit each.
REQ-010 SHALL have outputs MEM_AluResult (32 bits), MEM_WriteData (32 bits) and MEMRegRd (5 bits).
REQ-011 SHALL have outputs MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_MemToReg, MEM_Zero and MEM_Ovf, 1 bit each.

Function
REQ-012 SHALL select operand A as EX_RsData when ForwardA is 00 or 11, the registered MEM_AluResult when 10, and WB_Data when 01.
REQ-013 SHALL select the forwarded rt value by the same rule using ForwardB.
REQ-014 SHALL set operand B to EX_Imm when EX_AluSrc = 1, otherwise to the forwarded rt value.
REQ-015 SHALL compute one combinational ALU result per cycle: ADD, SUB, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL, SRL, SRA (shift B by EX_Shamt), SLLV, SRLV, SRAV (shift B by A[4:0]), LUI (B<<16).
REQ-016 SHALL produce 0 for any undefined EX_AluOp code and raise no flag.
REQ-017 SHALL wrap arithmetic modulo 2^32, with Ovf set only on signed overflow of ADD or SUB.
REQ-018 SHALL set Zero when the 32-bit result equals 0.
REQ-019 SHALL use a one-cycle latency: inputs sampled at edge N appear on MEM_* outputs after edge N.
REQ-020 SHALL always take MEM_WriteData from the forwarded rt value, never from operand B.
REQ-021 SHALL apply update priority per edge in the order reset, then i_flush, then i_stall, then normal load.
REQ-022 SHALL, on flush, zero the five control outputs (RegWrite, MemRead, MemWrite, MemToReg, Ovf) and MEMRegRd, leaving the data outputs don't-care and driven as 0.
REQ-023 SHALL, on stall without flush, hold every output at its previous value.
REQ-024 SHALL, when stalled with ForwardA = 10, feed the held MEM_AluResult back consistently with no combinational loop.
REQ-025 SHALL force MEM_RegWrite to 0 on a signed overflow of ADD or SUB, while still registering Ovf = 1.

Reset
REQ-026 SHALL, on reset, drive all outputs to 0 on the next edge regardless of i_stall and i_flush.
REQ-027 SHALL, when reset is asserted mid-stall, discard the held value.
REQ-028 SHALL, in the first cycle after reset deasserts, perform a normal load.

Structure
REQ-029 SHALL take the ALU opcode constants and the forward-select codes (FWD_ID = 00, FWD_WB = 01, FWD_MEM = 10) from the shared package mips_pkg.
REQ-030 SHALL implement the ALU as the purely combinational sub-module alu, instantiated once.
REQ-031 SHALL implement operand muxes and the EX/MEM register in ex_stage.

Verification
REQ-032 SHALL cover: ADD with A = 0x7FFFFFFF, B = 1, Fwd = 00 -> MEM_AluResult = 0x80000000, Ovf = 1, MEM_RegWrite = 0 one cycle later.
REQ-033 SHALL cover: ForwardA = 10 with the previous result 5, EX_RsData = 9, ADD with imm 3 -> 8; then ForwardA = 01 with WB_Data = 100 -> 103.
REQ-034 SHALL cover: SUB with A = B = 0x1234 -> result 0, Zero = 1; SLT with -1 vs 1 -> 1; SLTU with -1 vs 1 -> 0.
REQ-035 SHALL cover: i_stall held 3 cycles while inputs change -> outputs constant; i_flush asserted with i_stall -> control outputs and MEMRegRd = 0.
REQ-036 SHALL cover: reset asserted during a stall with MemWrite = 1 held -> all outputs 0 next edge; first post-reset load passes through.
REQ-037 SHALL cover: SRA of 0x80000000 by shamt 4 -> 0xF8000000; SRLV by A = 36 (uses A[4:0] = 4) -> 0x08000000.
